// File: rtl/ras_stack.sv
// Return address stack: push/pop/restore of a wrapping top-of-stack index with saturating count.
// Optional macro RAS_STACK_RET_VALID_EN adds ret_valid = (ras_count != 0).
module ras_stack #(
    parameter int unsigned RAS_ENTRIES     = 16,
    parameter int unsigned LOG_RAS_ENTRIES = 4,
    parameter int unsigned CNT_WIDTH       = 5
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       push_valid,
    input  logic [37:0]                push_pc38,
    input  logic                       pop_valid,
    input  logic                       restore_valid,
    input  logic [LOG_RAS_ENTRIES-1:0] restore_ras_index,
    input  logic [CNT_WIDTH-1:0]       restore_ras_count,
    output logic [37:0]                ret_pc38,
    output logic [LOG_RAS_ENTRIES-1:0] ras_index,
    output logic [CNT_WIDTH-1:0]       ras_count
`ifdef RAS_STACK_RET_VALID_EN
    ,
    output logic                       ret_valid
`endif
);

    localparam logic [CNT_WIDTH-1:0]       MAX_CNT = CNT_WIDTH'(RAS_ENTRIES);
    localparam logic [CNT_WIDTH-1:0]       CNT_ONE = CNT_WIDTH'(1);
    localparam logic [LOG_RAS_ENTRIES-1:0] IDX_ONE = LOG_RAS_ENTRIES'(1);

    logic [37:0]                entry_q [RAS_ENTRIES];
    logic [LOG_RAS_ENTRIES-1:0] index_q, index_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;
    logic                       wr_en_d;
    logic [LOG_RAS_ENTRIES-1:0] wr_idx_d;

    always_comb begin
        index_d  = index_q;
        count_d  = count_q;
        wr_en_d  = 1'b0;
        wr_idx_d = index_q;
        if (restore_valid) begin
            index_d = restore_ras_index;
            count_d = (restore_ras_count > MAX_CNT) ? MAX_CNT : restore_ras_count;
        end else if (push_valid && pop_valid) begin
            // RET_L: replace the top in place, pointer state untouched
            wr_en_d = 1'b1;
        end else if (push_valid) begin
            index_d  = index_q + IDX_ONE;
            wr_en_d  = 1'b1;
            wr_idx_d = index_q + IDX_ONE;
            count_d  = (count_q >= MAX_CNT) ? MAX_CNT : count_q + CNT_ONE;
        end else if (pop_valid) begin
            index_d = index_q - IDX_ONE;
            count_d = (count_q == '0) ? '0 : count_q - CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            index_q <= '1;
            count_q <= '0;
            entry_q <= '{default: '0};
        end else begin
            index_q <= index_d;
            count_q <= count_d;
            if (wr_en_d) begin
                entry_q[wr_idx_d] <= push_pc38;
            end
        end
    end

    assign ret_pc38  = entry_q[index_q];
    assign ras_index = index_q;
    assign ras_count = count_q;
`ifdef RAS_STACK_RET_VALID_EN
    assign ret_valid = (count_q != '0);
`endif

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack: directed scenarios then random traffic against a behavioural model.
module tb_ras_stack;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        push_valid;
    logic [37:0] push_pc38;
    logic        pop_valid;
    logic        restore_valid;
    logic [3:0]  restore_ras_index;
    logic [4:0]  restore_ras_count;
    logic [37:0] ret_pc38;
    logic [3:0]  ras_index;
    logic [4:0]  ras_count;
`ifdef RAS_STACK_RET_VALID_EN
    logic        ret_valid;
`endif

    ras_stack #(
        .RAS_ENTRIES    (16),
        .LOG_RAS_ENTRIES(4),
        .CNT_WIDTH      (5)
    ) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .push_valid       (push_valid),
        .push_pc38        (push_pc38),
        .pop_valid        (pop_valid),
        .restore_valid    (restore_valid),
        .restore_ras_index(restore_ras_index),
        .restore_ras_count(restore_ras_count),
        .ret_pc38         (ret_pc38),
        .ras_index        (ras_index),
        .ras_count        (ras_count)
`ifdef RAS_STACK_RET_VALID_EN
        ,
        .ret_valid        (ret_valid)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int fails = 0;

    // Behavioural model: a 16-slot circular stack with integer pointer/count
    logic [37:0] m_mem [16];
    int          m_top;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit push, input logic [37:0] pc,
                              input bit pop, input bit rest, input int ri, input int rc);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_top = 15;
            m_cnt = 0;
        end else if (rest) begin
            m_top = ri;
            m_cnt = (rc > 16) ? 16 : rc;
        end else if (push && pop) begin
            m_mem[m_top] = pc;
        end else if (push) begin
            m_top = (m_top + 1) % 16;
            m_mem[m_top] = pc;
            m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
        end else if (pop) begin
            m_top = (m_top + 15) % 16;
            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ret_pc38"}, 64'(ret_pc38), 64'(m_mem[m_top]));
        chk({tag, ".ras_index"}, 64'(ras_index), 64'(m_top));
        chk({tag, ".ras_count"}, 64'(ras_count), 64'(m_cnt));
`ifdef RAS_STACK_RET_VALID_EN
        chk({tag, ".ret_valid"}, 64'(ret_valid), 64'(m_cnt != 0));
`endif
    endtask

    task automatic cyc(input bit rst_n, input bit push, input logic [37:0] pc, input bit pop,
                       input bit rest, input logic [3:0] ri, input logic [4:0] rc, input string tag);
        nRST              = rst_n;
        push_valid        = push;
        push_pc38         = pc;
        pop_valid         = pop;
        restore_valid     = rest;
        restore_ras_index = ri;
        restore_ras_count = rc;
        @(posedge CLK);
        model_step(rst_n, push, pc, pop, rest, int'(ri), int'(rc));
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, "reset");
    endtask

    task automatic push_v(input logic [37:0] pc, input string tag);
        cyc(1'b1, 1'b1, pc, 1'b0, 1'b0, '0, '0, tag);
    endtask

    task automatic pop_v(input string tag);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, tag);
    endtask

    initial begin
        // Basic push/pop
        do_reset();
        chk("reset_index_const", 64'(ras_index), 64'hF);
        chk("reset_count_const", 64'(ras_count), 64'h0);
        push_v(38'h100, "push1");
        push_v(38'h200, "push2");
        push_v(38'h300, "push3");
        chk("p3_index_const", 64'(ras_index), 64'd2);
        chk("p3_ret_const", 64'(ret_pc38), 64'h300);
        pop_v("pop1");
        chk("pop1_ret_const", 64'(ret_pc38), 64'h200);
        chk("pop1_count_const", 64'(ras_count), 64'd2);

        // Overflow and underflow
        do_reset();
        for (int v = 1; v <= 17; v++) push_v(38'(v), "ovf_push");
        chk("ovf_count_const", 64'(ras_count), 64'd16);
        chk("ovf_index_const", 64'(ras_index), 64'd0);
        chk("ovf_entry0_const", 64'(ret_pc38), 64'd17);
        for (int k = 0; k < 16; k++) pop_v("drain_pop");
        chk("drain_count_const", 64'(ras_count), 64'd0);
        pop_v("underflow_pop");
        chk("underflow_index_const", 64'(ras_index), 64'hF);
        chk("underflow_count_const", 64'(ras_count), 64'd0);

        // Pop from reset
        do_reset();
        pop_v("pop_from_reset");
        chk("pfr_index_const", 64'(ras_index), 64'hE);

        // Push+pop same cycle
        do_reset();
        push_v(38'h111, "pp_pre1");
        push_v(38'h222, "pp_pre2");
        nRST = 1'b1; push_valid = 1'b1; push_pc38 = 38'hABC; pop_valid = 1'b1;
        restore_valid = 1'b0; restore_ras_index = '0; restore_ras_count = '0;
        #1;
        chk("pushpop_old_top", 64'(ret_pc38), 64'h222);
        cyc(1'b1, 1'b1, 38'hABC, 1'b1, 1'b0, '0, '0, "pushpop");
        chk("pushpop_ret_const", 64'(ret_pc38), 64'hABC);
        chk("pushpop_count_const", 64'(ras_count), 64'd2);

        // Checkpoint restore dominates a same-cycle push
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 4'd5, 5'd6, "capture");
        for (int k = 0; k < 4; k++) push_v(38'h5000 + 38'(k), "post_cap_push");
        cyc(1'b1, 1'b1, 38'hDEAD, 1'b0, 1'b1, 4'd5, 5'd6, "restore_w_push");
        chk("restore_index_const", 64'(ras_index), 64'd5);
        chk("restore_count_const", 64'(ras_count), 64'd6);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 4'd3, 5'd20, "restore_clamp");
        chk("clamp_count_const", 64'(ras_count), 64'd16);

        // Reset dominates everything
        cyc(1'b0, 1'b1, 38'h77, 1'b1, 1'b1, 4'd9, 5'd9, "reset_dominates");
        push_v(38'h42, "first_push_after_reset");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            bit rst_n, push, pop, rest;
            r      = $urandom_range(0, 99);
            rst_n  = (r != 0);
            rest   = ($urandom_range(0, 15) == 0);
            push   = $urandom_range(0, 1) == 1;
            pop    = $urandom_range(0, 2) == 0;
            cyc(rst_n, push, {6'($urandom), 32'($urandom)}, pop, rest,
                4'($urandom), 5'($urandom), "random");
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
